btn_press_decoder: RTL

//  Input-side counterpart of the LED blinker: user-indication input. Samples a raw

---
 rtl/btn_press_decoder_pkg.sv | 8 +
 rtl/btn_press_decoder_tick_divider.sv | 14 +
 rtl/btn_press_decoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/btn_press_decoder_pkg.sv
// btn_press_decoder_pkg: shared FSM state encoding for the button press decoder.
package btn_press_decoder_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/btn_press_decoder_tick_divider.sv
// tick_divider: free-running 2^DW+1 cycle prescaler; tick is the counter MSB.
module tick_divider #(
  parameter int DW = 15
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [DW:0] div_q;
  assign tick = div_q[DW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_q <= '0;
    else        div_q <= tick ? '0 : div_q + 1'b1;
endmodule

// File: rtl/btn_press_decoder.sv
// btn_press_decoder: debounces an active-low button pad and reports SHORT/LONG presses via valid/ack.
module btn_press_decoder
  import btn_press_decoder_pkg::*;
#(
  parameter int DW   = 15,
  parameter int TW   = 8,
  parameter int DEB  = 3,
  parameter int LONG = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic ena,
  input  logic evt_ack,
  output logic btn_level,
  output logic evt_valid,
  output logic evt_long,
  output logic evt_ovf
);
  localparam logic [TW-1:0] DEB_M1  = TW'(DEB - 1);
  localparam logic [TW-1:0] LONG_M1 = TW'(LONG - 1);
  logic          tick, raw, level_q;
  logic [1:0]    sync_q;
  logic [TW-1:0] deb_q, timer_q, timer_d, timer_inc;
  state_e        state_q, state_d;
  logic          emit, emit_long, ack_hit;
  logic          valid_q, valid_d, long_q, long_d, ovf_q, ovf_d;
  tick_divider #(.DW(DW)) u_div (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign raw       = ~sync_q[1];
  assign timer_inc = timer_q + 1'b1;
  assign ack_hit   = evt_ack & valid_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], btn_n};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      deb_q   <= '0;
      level_q <= 1'b0;
    end else if (tick) begin
      if (raw == level_q) deb_q <= '0;
      else if (deb_q == DEB_M1) begin
        deb_q   <= '0;
        level_q <= ~level_q;
      end else deb_q <= deb_q + 1'b1;
    end
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    emit      = 1'b0;
    emit_long = 1'b0;
    if (tick)
      case (state_q)
        IDLE:
          if (level_q) begin
            state_d = PRESS;
            timer_d = '0;
          end
        PRESS:
          if (!level_q) begin
            emit    = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_inc;
            if (timer_inc == LONG_M1) begin
              emit      = 1'b1;
              emit_long = 1'b1;
              state_d   = HOLD;
            end
          end
        HOLD:    state_d = level_q ? HOLD : IDLE;
        default: state_d = IDLE;
      endcase
    if (!ena) begin
      state_d = IDLE;
      timer_d = '0;
      emit    = 1'b0;
    end
  end
  // a fresh emit beats an ack landing in the same cycle; overwrite only counts if the old event was not acked
  assign valid_d = ena & (emit | (valid_q & ~evt_ack));
  assign long_d  = ena & (emit ? emit_long : (long_q & ~ack_hit));
  assign ovf_d   = ena & ((emit & valid_q & ~evt_ack) | (ovf_q & ~ack_hit));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      valid_q <= 1'b0;
      long_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      long_q  <= long_d;
      ovf_q   <= ovf_d;
    end
  assign btn_level = level_q;
  assign evt_valid = valid_q;
  assign evt_long  = long_q;
  assign evt_ovf   = ovf_q;
endmodule
